cicero_jtag_cmd_controller: RTL and testbench
=============================================

Name: cicero_jtag_cmd_controller

Overview:
Downstream consumer of the virtual JTAG adapter's register bank. It brings the quasi-static tck-domain registers (command, address, start/end CC pointers, data_in) into the system clock domain and decodes each new host command. It executes the command against the CICERO instruction memory and the regex engine start/done handshake. It returns the status and data_out words that the adapter captures on its next Capture-DR.

Parameters:
ADDR_WIDTH, 9, instruction-memory word address width; address[ADDR_WIDTH-1:0] is used, upper bits ignored.
SETTLE_CYCLES, 3, clk cycles to wait after a synchronized toggle edge before sampling the other buses (range 2..15).
RD_LATENCY, 1, instruction-memory read latency in clk cycles (range 1..4).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
command  in  32  tck-domain; [3:0] opcode, [31] toggle (sequence) bit, [30:4] ignored
address  in  32  tck-domain memory address
start_cc_pointer  in  32  tck-domain engine start pointer
end_cc_pointer  in  32  tck-domain engine end pointer
data_in  in  32  tck-domain memory write data
status  out  32  status word to adapter
data_out  out  32  read-back word to adapter
mem_addr  out  ADDR_WIDTH  instruction-memory address
mem_wdata  out  32  instruction-memory write data
mem_we  out  1  one-cycle write strobe
mem_re  out  1  one-cycle read strobe
mem_rdata  in  32  read data, valid RD_LATENCY cycles after mem_re
eng_start  out  1  engine start request, held until eng_ack
eng_start_ptr  out  32  registered start pointer
eng_end_ptr  out  32  registered end pointer
eng_ack  in  1  engine accepted start
eng_done  in  1  one-cycle pulse at end of run
eng_accept  in  1  match result, sampled with eng_done

Behaviour:
- Reset (async assert, sync release): every output is 0 except status[0]=1 (ready). The state machine enters IDLE. sync_toggle and last_toggle are cleared to 0.
- CDC: command[31] goes through a 2-flop synchronizer. All other inputs are sampled only in CAPTURE after the settle count. The host must not change them until status[31] echoes the toggle.
- A new command is a synchronized toggle != last_toggle while in IDLE. A toggle change seen in any other state is held off until the block returns to IDLE. It is not lost.
- Opcodes: 0 NOP, 1 WRITE_MEM, 2 READ_MEM, 3 START, 4 CLEAR (clears status[2] match, status[3] error, status[1] done), 5 READ_PTRS (data_out={eng_end_ptr[15:0],eng_start_ptr[15:0]}). Opcodes 6..15 are illegal: set error and complete as NOP.
- FSM:
  - IDLE -> CAPTURE on a new command; status[0]=0.
  - CAPTURE counts SETTLE_CYCLES, then registers all buses and the opcode -> DECODE.
  - DECODE routes by opcode:
    - WRITE_MEM -> MEM_WR: one cycle with mem_we=1, mem_addr and mem_wdata from the captured values.
    - READ_MEM -> MEM_RD: mem_re for 1 cycle. After RD_LATENCY cycles, data_out <= mem_rdata.
    - START -> ENG_REQ: eng_start=1 until eng_ack is sampled high; the start cycle clears status[1] and status[2]. Then -> ENG_RUN, which waits for eng_done. On eng_done: status[2] <= eng_accept, status[1] <= 1.
    - Others -> DONE directly.
  - DONE (1 cycle): last_toggle <= captured toggle, status[31] <= captured toggle, status[7:4] <= opcode, status[0] <= 1 -> IDLE.
- Status word: [0] ready, [1] engine done, [2] match, [3] error, [7:4] last opcode, [8] engine busy (ENG_REQ/ENG_RUN), [30:9]=0, [31] toggle echo.
- eng_ack and eng_done arriving in the same cycle inside ENG_REQ: both are honoured, and the block goes straight to DONE with the result latched.
- eng_done while not in ENG_RUN/ENG_REQ is ignored.
- Reset mid-run: everything returns to reset values immediately; eng_start drops asynchronously.
- A command issued with the same toggle value as last_toggle is ignored (a duplicate write).

Test Plan:
1. Reset release, hold command=0 -> status=32'h0000_0001, all strobes 0, eng_start=0.
2. address=5, data_in=32'hDEAD_BEEF, then command=32'h8000_0001 -> exactly one mem_we pulse with mem_addr=5 and mem_wdata=32'hDEADBEEF; status then reads 32'h8000_0011.
3. command=32'h0000_0002 after test 2, memory returns 32'hDEAD_BEEF at RD_LATENCY -> data_out=32'hDEADBEEF and status[31]=0.
4. start_cc_pointer=3, end_cc_pointer=40, START with toggle flip; ack after 4 cycles; eng_done with eng_accept=1 after 20 more -> eng_start high for exactly 4 cycles; eng_start_ptr=3; status[8]=1 during the run; final status[2:0]=3'b111.
5. Opcode 9 -> status[3]=1 with no memory or engine activity; then CLEAR -> status[3:1]=0.
6. Toggle flipped during ENG_RUN -> no capture until after eng_done, then the command executes once. Separately, rst_n asserted mid-ENG_RUN -> eng_start=0 and status=1 immediately.

Source files
------------

// File: rtl/cicero_jtag_cmd_controller.sv
`timescale 1ns/1ps
// Command controller: brings the quasi-static JTAG register bank into clk,
// decodes each toggled host command and drives instruction memory / engine.
module cicero_jtag_cmd_controller #(
  parameter int unsigned ADDR_WIDTH    = 9,
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter int unsigned RD_LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           command,
  input  logic [31:0]           address,
  input  logic [31:0]           start_cc_pointer,
  input  logic [31:0]           end_cc_pointer,
  input  logic [31:0]           data_in,
  output logic [31:0]           status,
  output logic [31:0]           data_out,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [31:0]           mem_rdata,
  output logic                  eng_start,
  output logic [31:0]           eng_start_ptr,
  output logic [31:0]           eng_end_ptr,
  input  logic                  eng_ack,
  input  logic                  eng_done,
  input  logic                  eng_accept
);

  localparam int unsigned CNT_W = 4;
  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_WRITE = 4'd1;
  localparam logic [3:0] OP_READ  = 4'd2;
  localparam logic [3:0] OP_START = 4'd3;
  localparam logic [3:0] OP_CLEAR = 4'd4;
  localparam logic [3:0] OP_PTRS  = 4'd5;

  typedef enum logic [2:0] {
    S_IDLE, S_CAPTURE, S_DECODE, S_MEM_WR, S_MEM_RD, S_ENG_REQ, S_ENG_RUN, S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic                    meta_q, meta_d;
  logic                    sync_toggle_q, sync_toggle_d;
  logic                    last_toggle_q, last_toggle_d;
  logic                    tog_q, tog_d;
  logic [3:0]              opcode_q, opcode_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]             mem_wdata_q, mem_wdata_d;
  logic                    mem_we_q, mem_we_d;
  logic                    mem_re_q, mem_re_d;
  logic                    eng_start_q, eng_start_d;
  logic [31:0]             eng_start_ptr_q, eng_start_ptr_d;
  logic [31:0]             eng_end_ptr_q, eng_end_ptr_d;
  logic [31:0]             data_out_q, data_out_d;
  logic                    ready_q, ready_d;
  logic                    edone_q, edone_d;
  logic                    match_q, match_d;
  logic                    err_q, err_d;
  logic [3:0]              op_q, op_d;
  logic                    busy_q, busy_d;
  logic                    echo_q, echo_d;

  // Reserved command bits and address bits above the memory range carry no meaning.
  logic unused_bits;
  assign unused_bits = ^{command[30:4], address[31:ADDR_WIDTH]};

  // State and output registers; reset leaves only the ready bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      meta_q          <= 1'b0;
      sync_toggle_q   <= 1'b0;
      last_toggle_q   <= 1'b0;
      tog_q           <= 1'b0;
      opcode_q        <= 4'd0;
      cnt_q           <= '0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= 32'd0;
      mem_we_q        <= 1'b0;
      mem_re_q        <= 1'b0;
      eng_start_q     <= 1'b0;
      eng_start_ptr_q <= 32'd0;
      eng_end_ptr_q   <= 32'd0;
      data_out_q      <= 32'd0;
      ready_q         <= 1'b1;
      edone_q         <= 1'b0;
      match_q         <= 1'b0;
      err_q           <= 1'b0;
      op_q            <= 4'd0;
      busy_q          <= 1'b0;
      echo_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      meta_q          <= meta_d;
      sync_toggle_q   <= sync_toggle_d;
      last_toggle_q   <= last_toggle_d;
      tog_q           <= tog_d;
      opcode_q        <= opcode_d;
      cnt_q           <= cnt_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_we_q        <= mem_we_d;
      mem_re_q        <= mem_re_d;
      eng_start_q     <= eng_start_d;
      eng_start_ptr_q <= eng_start_ptr_d;
      eng_end_ptr_q   <= eng_end_ptr_d;
      data_out_q      <= data_out_d;
      ready_q         <= ready_d;
      edone_q         <= edone_d;
      match_q         <= match_d;
      err_q           <= err_d;
      op_q            <= op_d;
      busy_q          <= busy_d;
      echo_q          <= echo_d;
    end
  end

  // Next-state and output decode; buses are only sampled at the end of the settle window.
  always_comb begin
    state_d         = state_q;
    meta_d          = command[31];
    sync_toggle_d   = meta_q;
    last_toggle_d   = last_toggle_q;
    tog_d           = tog_q;
    opcode_d        = opcode_q;
    cnt_d           = cnt_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    mem_we_d        = 1'b0;
    mem_re_d        = 1'b0;
    eng_start_d     = eng_start_q;
    eng_start_ptr_d = eng_start_ptr_q;
    eng_end_ptr_d   = eng_end_ptr_q;
    data_out_d      = data_out_q;
    ready_d         = ready_q;
    edone_d         = edone_q;
    match_d         = match_q;
    err_d           = err_q;
    op_d            = op_q;
    echo_d          = echo_q;

    case (state_q)
      S_IDLE: begin
        if (sync_toggle_q != last_toggle_q) begin
          state_d = S_CAPTURE;
          cnt_d   = '0;
          ready_d = 1'b0;
        end
      end
      S_CAPTURE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          tog_d           = sync_toggle_q;
          opcode_d        = command[3:0];
          mem_addr_d      = address[ADDR_WIDTH-1:0];
          mem_wdata_d     = data_in;
          eng_start_ptr_d = start_cc_pointer;
          eng_end_ptr_d   = end_cc_pointer;
          state_d         = S_DECODE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DECODE: begin
        state_d = S_DONE;
        case (opcode_q)
          OP_NOP: ;
          OP_WRITE: begin
            mem_we_d = 1'b1;
            state_d  = S_MEM_WR;
          end
          OP_READ: begin
            mem_re_d = 1'b1;
            cnt_d    = '0;
            state_d  = S_MEM_RD;
          end
          OP_START: begin
            eng_start_d = 1'b1;
            edone_d     = 1'b0;
            match_d     = 1'b0;
            state_d     = S_ENG_REQ;
          end
          OP_CLEAR: begin
            edone_d = 1'b0;
            match_d = 1'b0;
            err_d   = 1'b0;
          end
          OP_PTRS:  data_out_d = {eng_end_ptr_q[15:0], eng_start_ptr_q[15:0]};
          default:  err_d = 1'b1;
        endcase
      end
      S_MEM_WR: state_d = S_DONE;
      S_MEM_RD: begin
        if (cnt_q == CNT_W'(RD_LATENCY)) begin
          data_out_d = mem_rdata;
          state_d    = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ENG_REQ: begin
        if (eng_ack) begin
          eng_start_d = 1'b0;
          if (eng_done) begin
            edone_d = 1'b1;
            match_d = eng_accept;
            state_d = S_DONE;
          end else begin
            state_d = S_ENG_RUN;
          end
        end
      end
      S_ENG_RUN: begin
        if (eng_done) begin
          edone_d = 1'b1;
          match_d = eng_accept;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        last_toggle_d = tog_q;
        echo_d        = tog_q;
        op_d          = opcode_q;
        ready_d       = 1'b1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_ENG_REQ) || (state_d == S_ENG_RUN);
  end

  assign status        = {echo_q, 22'h0, busy_q, op_q, err_q, match_q, edone_q, ready_q};
  assign data_out      = data_out_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_we        = mem_we_q;
  assign mem_re        = mem_re_q;
  assign eng_start     = eng_start_q;
  assign eng_start_ptr = eng_start_ptr_q;
  assign eng_end_ptr   = eng_end_ptr_q;

endmodule

// File: tb/tb_cicero_jtag_cmd_controller.sv
`timescale 1ns/1ps
// Bench for cicero_jtag_cmd_controller: a transaction-level model predicts the
// status/data_out words each host command must leave behind.
module tb_cicero_jtag_cmd_controller;

  localparam int unsigned AW = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   command, address, start_cc_pointer, end_cc_pointer, data_in;
  logic [31:0]   status, data_out, mem_wdata, mem_rdata, eng_start_ptr, eng_end_ptr;
  logic [AW-1:0] mem_addr;
  logic          mem_we, mem_re, eng_start, eng_ack, eng_done, eng_accept;

  cicero_jtag_cmd_controller #(.ADDR_WIDTH(AW), .SETTLE_CYCLES(3), .RD_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n), .command(command), .address(address),
    .start_cc_pointer(start_cc_pointer), .end_cc_pointer(end_cc_pointer),
    .data_in(data_in), .status(status), .data_out(data_out),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .eng_start(eng_start), .eng_start_ptr(eng_start_ptr),
    .eng_end_ptr(eng_end_ptr), .eng_ack(eng_ack), .eng_done(eng_done),
    .eng_accept(eng_accept)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        tog;
    logic [3:0]  op;
    logic [31:0] addr, wdata, sp, ep, status, dout;
  } exp_t;

  exp_t        pq[$];
  logic [31:0] m_mem [int];
  logic        m_edone, m_match, m_err;
  logic [31:0] m_dout, exp_status, exp_dout;

  int total = 0, bad = 0;
  int we_cnt, re_cnt, start_hi, busy_seen;
  int eng_phase, eng_cnt, ack_dly, done_dly;
  logic same_cyc, acc_val;
  logic [31:0] tb_mem [0:511];
  logic        rd_pend;
  logic [31:0] rd_val;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", name, got, exp);
    end
  endtask

  // Predict the effect of one command, queue the expectation, then raise the toggle.
  task automatic issue(input logic [3:0] op, input logic tog);
    exp_t e;
    case (op)
      4'd0: ;
      4'd1: m_mem[int'(address[AW-1:0])] = data_in;
      4'd2: m_dout = m_mem.exists(int'(address[AW-1:0])) ? m_mem[int'(address[AW-1:0])] : 32'h0;
      4'd3: begin m_edone = 1'b1; m_match = acc_val; end
      4'd4: begin m_edone = 1'b0; m_match = 1'b0; m_err = 1'b0; end
      4'd5: m_dout = {end_cc_pointer[15:0], start_cc_pointer[15:0]};
      default: m_err = 1'b1;
    endcase
    e.tog = tog; e.op = op; e.addr = address; e.wdata = data_in;
    e.sp = start_cc_pointer; e.ep = end_cc_pointer;
    e.status = {tog, 22'h0, 1'b0, op, m_err, m_match, m_edone, 1'b1};
    e.dout = m_dout;
    pq.push_back(e);
    command = {tog, 27'h0, op};
  endtask

  task automatic wait_idle(input int max, input string tag);
    int n = 0;
    while (pq.size() != 0 && n < max) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (pq.size() != 0) begin
      bad++;
      $display("FAIL %s timeout pending=%0d after %0d cycles", tag, pq.size(), n);
      pq.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Instruction memory: read data appears one cycle after mem_re, zero otherwise.
  initial begin
    mem_rdata = 32'h0;
    rd_pend   = 1'b0;
    rd_val    = 32'h0;
    forever begin
      @(negedge clk);
      mem_rdata = rd_pend ? rd_val : 32'h0;
      rd_pend   = mem_re;
      rd_val    = tb_mem[mem_addr];
      if (mem_we) tb_mem[mem_addr] = mem_wdata;
    end
  end

  // Engine: ack after ack_dly cycles of eng_start, done after done_dly more.
  initial begin
    eng_ack = 1'b0; eng_done = 1'b0; eng_accept = 1'b0;
    forever begin
      @(posedge clk); #1;
      eng_ack = 1'b0; eng_done = 1'b0;
      if (eng_phase == 1 && eng_start) begin
        eng_cnt++;
        if (eng_cnt == ack_dly) begin
          eng_ack = 1'b1;
          eng_cnt = 0;
          if (same_cyc) begin
            eng_done = 1'b1; eng_accept = acc_val; eng_phase = 0;
          end else begin
            eng_phase = 2;
          end
        end
      end else if (eng_phase == 2) begin
        eng_cnt++;
        if (eng_cnt == done_dly) begin
          eng_done = 1'b1; eng_accept = acc_val; eng_phase = 0; eng_cnt = 0;
        end
      end
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (status[30:9] != 22'h0) chk("status_pad", 32'(status[30:9]), 32'h0);
        if (eng_start) begin
          start_hi++;
          chk("busy_with_start", 32'(status[8]), 32'h1);
          if (pq.size() > 0) begin
            chk("start_op", 32'(pq[0].op), 32'h3);
            chk("start_ptr", eng_start_ptr, pq[0].sp);
            chk("end_ptr", eng_end_ptr, pq[0].ep);
          end else chk("start_no_cmd", 32'(pq.size()), 32'h1);
        end
        if (status[8]) busy_seen = 1;
        if (mem_we) begin
          we_cnt++;
          if (pq.size() > 0) begin
            chk("we_op", 32'(pq[0].op), 32'h1);
            chk("we_addr", 32'(mem_addr), 32'(pq[0].addr[AW-1:0]));
            chk("we_data", mem_wdata, pq[0].wdata);
          end else chk("we_no_cmd", 32'(pq.size()), 32'h1);
        end
        if (mem_re) begin
          re_cnt++;
          if (pq.size() > 0) begin
            chk("re_op", 32'(pq[0].op), 32'h2);
            chk("re_addr", 32'(mem_addr), 32'(pq[0].addr[AW-1:0]));
          end else chk("re_no_cmd", 32'(pq.size()), 32'h1);
        end
        if (status[0]) begin
          if (pq.size() > 0 && status[31] == pq[0].tog) begin
            chk("cmd_status", status, pq[0].status);
            chk("cmd_dout", data_out, pq[0].dout);
            exp_status = pq[0].status;
            exp_dout   = pq[0].dout;
            void'(pq.pop_front());
          end else begin
            chk("idle_status", status, exp_status);
            chk("idle_dout", data_out, exp_dout);
          end
        end else begin
          chk("busy_needs_cmd", 32'(pq.size() > 0), 32'h1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; command = 32'h0; address = 32'h0; data_in = 32'h0;
    start_cc_pointer = 32'h0; end_cc_pointer = 32'h0;
    m_edone = 1'b0; m_match = 1'b0; m_err = 1'b0; m_dout = 32'h0;
    exp_status = 32'h1; exp_dout = 32'h0;
    we_cnt = 0; re_cnt = 0; start_hi = 0; busy_seen = 0;
    eng_phase = 0; eng_cnt = 0; ack_dly = 4; done_dly = 20; same_cyc = 1'b0; acc_val = 1'b0;
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("rst_status", status, 32'h0000_0001);
    chk("rst_strobes", {29'h0, mem_we, mem_re, eng_start}, 32'h0);
    chk("rst_dout", data_out, 32'h0);

    // Write one word.
    address = 32'd5; data_in = 32'hDEAD_BEEF; we_cnt = 0;
    issue(4'd1, 1'b1);
    wait_idle(60, "write");
    chk("wr_pulses", 32'(we_cnt), 32'd1);
    chk("wr_status_lit", status, 32'h8000_0011);

    // Read it back.
    re_cnt = 0;
    issue(4'd2, 1'b0);
    wait_idle(60, "read");
    chk("rd_dout_lit", data_out, 32'hDEAD_BEEF);
    chk("rd_echo", 32'(status[31]), 32'h0);
    chk("rd_pulses", 32'(re_cnt), 32'd1);

    // Engine run with delayed ack and accept.
    start_cc_pointer = 32'd3; end_cc_pointer = 32'd40;
    ack_dly = 4; done_dly = 20; same_cyc = 1'b0; acc_val = 1'b1;
    start_hi = 0; busy_seen = 0; eng_cnt = 0; eng_phase = 1;
    issue(4'd3, 1'b1);
    wait_idle(120, "start");
    chk("start_hi_cycles", 32'(start_hi), 32'd4);
    chk("start_ptr_lit", eng_start_ptr, 32'd3);
    chk("busy_seen", 32'(busy_seen), 32'd1);
    chk("start_low3", 32'(status[2:0]), 32'h7);
    chk("start_status_lit", status, 32'h8000_0037);

    // Illegal opcode, then clear.
    we_cnt = 0; re_cnt = 0; start_hi = 0;
    issue(4'd9, 1'b0);
    wait_idle(60, "illegal");
    chk("illegal_err", 32'(status[3]), 32'h1);
    chk("illegal_quiet", 32'(we_cnt + re_cnt + start_hi), 32'h0);
    chk("illegal_status_lit", status, 32'h0000_009F);
    issue(4'd4, 1'b1);
    wait_idle(60, "clear");
    chk("clear_bits", 32'(status[3:1]), 32'h0);

    // Pointer read-back.
    issue(4'd5, 1'b0);
    wait_idle(60, "ptrs");
    chk("ptrs_dout_lit", data_out, 32'h0028_0003);

    // Same toggle as last command: must be ignored.
    we_cnt = 0;
    command = 32'h0000_0001;
    repeat (20) @(posedge clk); #1;
    chk("dup_no_write", 32'(we_cnt), 32'h0);
    chk("dup_status_lit", status, 32'h0000_0051);

    // New toggle while the engine runs waits for completion.
    ack_dly = 2; done_dly = 15; same_cyc = 1'b0; acc_val = 1'b0; eng_cnt = 0; eng_phase = 1;
    issue(4'd3, 1'b1);
    repeat (12) @(posedge clk); #1;
    chk("run_busy", 32'(status[8]), 32'h1);
    issue(4'd0, 1'b0);
    repeat (4) @(posedge clk); #1;
    chk("held_off", 32'(status[0]), 32'h0);
    wait_idle(150, "holdoff");
    chk("holdoff_status_lit", status, 32'h0000_0003);

    // Ack and done in the same cycle.
    ack_dly = 3; same_cyc = 1'b1; acc_val = 1'b1; eng_cnt = 0; eng_phase = 1;
    issue(4'd3, 1'b1);
    wait_idle(80, "same_cycle");
    chk("same_cycle_lit", status, 32'h8000_0037);

    // Reset in the middle of a run.
    ack_dly = 2; done_dly = 60; same_cyc = 1'b0; acc_val = 1'b1; eng_cnt = 0; eng_phase = 1;
    issue(4'd3, 1'b0);
    repeat (16) @(posedge clk); #1;
    chk("pre_rst_busy", 32'(status[8]), 32'h1);
    rst_n = 1'b0;
    eng_phase = 0; eng_cnt = 0;
    #1;
    chk("midrst_status", status, 32'h0000_0001);
    chk("midrst_start", 32'(eng_start), 32'h0);
    chk("midrst_dout", data_out, 32'h0);
    pq.delete();
    m_edone = 1'b0; m_match = 1'b0; m_err = 1'b0; m_dout = 32'h0;
    exp_status = 32'h1; exp_dout = 32'h0;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk); #1;
    chk("post_rst_idle", status, 32'h0000_0001);
    issue(4'd0, 1'b1);
    wait_idle(60, "post_rst_nop");
    chk("post_rst_nop_lit", status, 32'h8000_0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
